uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the UART link. Accepts one 8-bit byte through a ready/start handshake and drives an idle-high serial line with a frame of 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1). Each bit is held for a fixed number of clock cycles. It is the transmit-side counterpart of the receive path's 9-bit LSB-first shift register (stop bit + packet data), and its frames must be decodable by that receiver unmodified.

## Interface
- BIT_PERIOD, 10, clock cycles per serial bit; legal range 2..1024.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tx_data  input  8  byte to send; sampled only when a start is accepted.
- tx_start  input  1  request to send tx_data; accepted only in a cycle where tx_ready=1.
- tx_ready  output  1  high when idle and able to accept a start.
- tx_done  output  1  one-cycle pulse after the stop bit of a frame completes.
- serial_out  output  1  serial line; 1 when idle.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - serial_out=1, tx_ready=1.
  - On tx_start=1: latch tx_data into a 9-bit shift register as {1'b1, tx_data}, clear the bit-timer and bit index, go to START.
- START: serial_out=0 for BIT_PERIOD cycles, then go to DATA.
- DATA:
  - serial_out = shift register bit 0.
  - Every BIT_PERIOD cycles, shift right by one and increment the bit index.
  - After the 8th data bit completes, go to STOP.
- STOP: serial_out=1 for BIT_PERIOD cycles, then go to IDLE and assert tx_done for that first IDLE cycle.
- Bit timer counts 0..BIT_PERIOD-1; width $clog2(BIT_PERIOD). Bit index counts 0..7; width 3.
- tx_start while tx_ready=0 is ignored. There is no queueing and no error flag.
- tx_data changes after acceptance have no effect on the frame in flight.
- tx_start in the tx_done cycle is accepted (state is IDLE). This gives back-to-back frames with no idle cycles between the stop bit and the next start bit beyond the handshake cycle.
- Reset asserted mid-frame:
  - State returns to IDLE immediately (asynchronously).
  - serial_out=1, tx_ready=1, tx_done=0.
  - The frame is abandoned with no done pulse.

## Timing
- Reset values: serial_out=1, tx_ready=1, tx_done=0, state IDLE, timer=0, index=0, shift register all 1s.
- All outputs are registered or decoded from registered state only; no combinational path from tx_start/tx_data to outputs.
- tx_start accepted at edge N:
  - serial_out falls to 0 and tx_ready falls to 0 after edge N.
  - Start bit spans cycles N+1..N+BIT_PERIOD.
- Data bit k (k=0..7) spans cycles N+1+(k+1)·BIT_PERIOD .. N+(k+2)·BIT_PERIOD.
- Stop bit spans cycles N+1+9·BIT_PERIOD .. N+10·BIT_PERIOD.
- In cycle N+10·BIT_PERIOD+1: tx_done=1 and tx_ready=1. tx_done returns to 0 the next cycle.
- Total busy time per frame: 10·BIT_PERIOD cycles.

## Structure
- Package uart_pkg holds:
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}
  - localparam DATA_BITS=8
  - localparam FRAME_BITS=10
- One sub-module is natural: uart_bit_timer.
  - A clear-able, enable-able counter with a rollover pulse at BIT_PERIOD-1.
  - Parameterized by BIT_PERIOD.
  - Drives both FSM bit advance and the shift strobe.
- FSM, shift register and bit index live in uart_tx.

## Test plan
- Reset then idle 50 cycles -> serial_out=1, tx_ready=1, tx_done=0 throughout.
- BIT_PERIOD=10, send 0xA5 -> serial_out bits 0,1,0,1,0,0,1,0,1,1 (start, LSB..MSB, stop), each exactly 10 cycles; tx_done pulses once at cycle 101 after acceptance.
- Send 0x00, then assert tx_start with 0xFF in the tx_done cycle -> second frame's start bit begins the next cycle; frames 0,00000000,1 then 0,11111111,1 with no extra idle.
- Pulse tx_start with 0x3C mid-frame of 0x81, and change tx_data -> ignored; line carries 0x81 only; one tx_done.
- Assert rst during data bit 4 of 0x55 -> serial_out=1 and tx_ready=1 immediately (before next edge); no tx_done; a new start after reset release sends a clean frame.
- Loopback: BIT_PERIOD=10, serial_out into the receive path, bytes 0x00, 0xFF, 0x5A, 0xC3 -> received packet_data matches each byte, stop_bit=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial line between a byte producer and uart_tx.
interface uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_done;
  logic       serial_out;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_ready,
    input  tx_done,
    input  serial_out
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_ready,
    output tx_done,
    output serial_out
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..BIT_PERIOD-1 while enabled and flags the last cycle of each bit.
module uart_bit_timer #(
  parameter int BIT_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(BIT_PERIOD - 1);

  logic [W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, each BIT_PERIOD clocks.
//   state | meaning
//   IDLE  | line high, ready for a byte
//   START | driving the start bit (0)
//   DATA  | driving shift_reg[0], one data bit per period
//   STOP  | driving the stop bit (1); done pulse on exit
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = 10
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  tx
);

  tx_state_t  state;
  logic [8:0] shift_reg;
  logic [2:0] bit_idx;
  logic       serial_q;
  logic       ready_q;
  logic       done_q;
  logic       tick;
  logic       timer_clr;
  logic       timer_en;

  // Timer is parked at zero in IDLE so every frame starts on a fresh bit boundary.
  assign timer_clr = (state == IDLE);
  assign timer_en  = (state != IDLE);

  uart_bit_timer #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '1;
      bit_idx   <= '0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx.tx_start) begin
            shift_reg <= {1'b1, tx.tx_data};
            bit_idx   <= '0;
            serial_q  <= 1'b0;
            ready_q   <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            serial_q <= shift_reg[0];
            state    <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            // Output is registered, so present the bit that lands in [0] after this shift.
            shift_reg <= {1'b1, shift_reg[8:1]};
            serial_q  <= shift_reg[1];
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              serial_q <= 1'b1;
              state    <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx.serial_out = serial_q;
  assign tx.tx_ready   = ready_q;
  assign tx.tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor decodes the line.
module tb_uart_tx;

  localparam int BP = 10;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] line;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];

  uart_tx_if bus ();

  uart_tx #(.BIT_PERIOD(BP)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called at a negedge; returns one time unit after the accepting posedge.
  task automatic send(input logic [7:0] d, input logic [9:0] line, input bit push);
    int guard;
    guard = 0;
    while (!bus.tx_ready && guard < 20 * BP) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_send", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    if (push) exp_q.push_back('{data: d, line: line});
    @(posedge clk);
    #1;
    chk("start_bit_immediate", 32'(bus.serial_out), 32'd0);
    chk("ready_low_after_accept", 32'(bus.tx_ready), 32'd0);
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.tx_done) break;
      if (cyc > 12 * BP) begin
        chk("done_wait_timeout", 32'(cyc), 32'(10 * BP + 1));
        break;
      end
    end
  endtask

  // Monitor: acts as the receive path, decoding each frame into a 9-bit LSB-first shift register.
  initial begin : monitor
    logic       prev;
    logic       aborted;
    logic       stable;
    logic       done_in_frame;
    logic [9:0] line;
    logic [8:0] rx_sr;
    exp_t       e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
        continue;
      end
      if (bus.tx_done) chk("unexpected_done", 32'(bus.tx_done), 32'd0);
      if (prev && !bus.serial_out) begin
        aborted       = 1'b0;
        stable        = 1'b1;
        done_in_frame = 1'b0;
        line          = '0;
        for (int i = 0; i < uart_pkg::FRAME_BITS * BP; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (i % BP == 0) line[i / BP] = bus.serial_out;
          else if (bus.serial_out !== line[i / BP]) stable = 1'b0;
          if (bus.tx_done) done_in_frame = 1'b1;
        end
        if (!aborted) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
          end else begin
            chk("done_after_stop", 32'(bus.tx_done), 32'd1);
            chk("ready_after_stop", 32'(bus.tx_ready), 32'd1);
            chk("bit_width_stable", 32'(stable), 32'd1);
            chk("no_done_in_frame", 32'(done_in_frame), 32'd0);
            rx_sr = '0;
            for (int b = 1; b < uart_pkg::FRAME_BITS; b++) rx_sr = {line[b], rx_sr[8:1]};
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", 32'(line), 32'h0);
              chk("unexpected_frame_q", 32'(exp_q.size()), 32'd1);
            end else begin
              e = exp_q.pop_front();
              chk("line_pattern", 32'(line), 32'(e.line));
              chk("rx_packet_data", 32'(rx_sr[7:0]), 32'(e.data));
              chk("rx_stop_bit", 32'(rx_sr[8]), 32'd1);
            end
          end
        end
        prev = aborted ? 1'b1 : bus.serial_out;
      end else begin
        prev = bus.serial_out;
      end
    end
  end

  initial begin : stimulus
    int cyc;
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_serial", 32'(bus.serial_out), 32'd1);
    chk("reset_ready", 32'(bus.tx_ready), 32'd1);
    chk("reset_done", 32'(bus.tx_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_serial", 32'(bus.serial_out), 32'd1);
      chk("idle_ready", 32'(bus.tx_ready), 32'd1);
      chk("idle_done", 32'(bus.tx_done), 32'd0);
    end

    // 0xA5: line 0,1,0,1,0,0,1,0,1,1 ; done 101 cycles after acceptance.
    send(8'hA5, 10'b1101001010, 1'b1);
    wait_done(cyc);
    chk("done_latency_a5", 32'(cyc), 32'd101);

    // Back-to-back: 0x00 then 0xFF started in the done cycle.
    send(8'h00, 10'b1000000000, 1'b1);
    wait_done(cyc);
    chk("done_latency_00", 32'(cyc), 32'd101);
    send(8'hFF, 10'b1111111110, 1'b1);
    wait_done(cyc);
    chk("done_latency_ff", 32'(cyc), 32'd101);

    // Start pulse and tx_data change mid-frame are ignored.
    send(8'h81, 10'b1100000010, 1'b1);
    repeat (3 * BP) @(negedge clk);
    bus.tx_data  = 8'h3C;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'hFF;
    wait_done(cyc);
    chk("done_latency_81", 32'(cyc), 32'd101 - 32'(3 * BP + 1));
    repeat (12 * BP) @(negedge clk);
    chk("ignored_start_no_frame", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 4 of 0x55.
    send(8'h55, 10'b1010101010, 1'b0);
    repeat (5 * BP + 3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_serial", 32'(bus.serial_out), 32'd1);
    chk("rst_mid_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_mid_done", 32'(bus.tx_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6 * BP; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(bus.tx_done), 32'd0);
    end
    send(8'h55, 10'b1010101010, 1'b1);
    wait_done(cyc);
    chk("done_latency_55", 32'(cyc), 32'd101);

    // Loopback bytes.
    send(8'h00, 10'b1000000000, 1'b1);
    wait_done(cyc);
    send(8'hFF, 10'b1111111110, 1'b1);
    wait_done(cyc);
    send(8'h5A, 10'b1010110100, 1'b1);
    wait_done(cyc);
    send(8'hC3, 10'b1110000110, 1'b1);
    wait_done(cyc);
    chk("done_latency_c3", 32'(cyc), 32'd101);

    repeat (30) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("final_idle_serial", 32'(bus.serial_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
